// File: rtl/config_loader.sv
// Serial configuration chain loader.
// Takes parallel config words over a valid/ready handshake and shifts them
// LSB first into a downstream serial config chain of CHAIN_LEN bits. A load
// is started by a one-cycle cfg_start pulse. Each load has the phases
// clear -> (load word -> shift word)* -> finish. Every output is registered
// and changes on the same edge as the state it belongs to.
module config_loader #(
    parameter int WORD_W     = 8,
    parameter int CHAIN_LEN  = 14,
    parameter int CLR_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_start,
    input  logic              word_valid,
    output logic              word_ready,
    input  logic [WORD_W-1:0] word_data,
    output logic              cfg_bit_out,
    output logic              cfg_shift,
    output logic              cfg_reset_out,
    output logic              busy,
    output logic              done
);

    // Bits still to be shifted for the whole chain; sized so CHAIN_LEN fits.
    localparam int BL_W = $clog2(CHAIN_LEN + 1);
    // The clear counter is at least one bit wide, even for CLR_CYCLES of 0.
    localparam int CC_W = (CLR_CYCLES < 1) ? 1 : $clog2(CLR_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        LOAD  = 3'd2,
        SHIFT = 3'd3,
        FIN   = 3'd4
    } state_t;

    state_t              state_reg;
    logic [WORD_W-1:0]   shreg_reg;
    logic [BL_W-1:0]     bits_left_reg;
    logic [BL_W-1:0]     word_cnt_reg;
    logic [CC_W-1:0]     clr_cnt_reg;

    logic                word_ready_reg;
    logic                cfg_bit_out_reg;
    logic                cfg_shift_reg;
    logic                cfg_reset_out_reg;
    logic                busy_reg;
    logic                done_reg;

    // Right-shifted copies of the shift register and of the incoming word.
    // The incoming word's bit 0 goes straight to the chain on capture, so
    // the shift register only needs to hold the remaining bits.
    logic [WORD_W-1:0]   shreg_next;
    logic [WORD_W-1:0]   word_next;

    // Number of bits to take from the word being accepted: the smaller of
    // WORD_W and what is left of the chain. Upper bits of a short final word
    // are simply never shifted out.
    logic [BL_W-1:0]     take_cnt;

    generate
        for (genvar gi = 0; gi < WORD_W - 1; gi++) begin : g_shift
            assign shreg_next[gi] = shreg_reg[gi+1];
            assign word_next[gi]  = word_data[gi+1];
        end
    endgenerate
    assign shreg_next[WORD_W-1] = 1'b0;
    assign word_next[WORD_W-1]  = 1'b0;

    // Clamp the per-word bit count to the remaining chain length.
    always_comb begin
        take_cnt = bits_left_reg;
        if (32'(bits_left_reg) >= 32'(WORD_W)) begin
            take_cnt = BL_W'(WORD_W);
        end
    end

    // Load sequencer: state, counters, shift register and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg         <= IDLE;
            shreg_reg         <= '0;
            bits_left_reg     <= '0;
            word_cnt_reg      <= '0;
            clr_cnt_reg       <= '0;
            word_ready_reg    <= 1'b0;
            cfg_bit_out_reg   <= 1'b0;
            cfg_shift_reg     <= 1'b0;
            cfg_reset_out_reg <= 1'b0;
            busy_reg          <= 1'b0;
            done_reg          <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    // Only cfg_start matters here; stray word_valid is ignored.
                    if (cfg_start) begin
                        state_reg         <= CLEAR;
                        bits_left_reg     <= BL_W'(CHAIN_LEN);
                        clr_cnt_reg       <= CC_W'(CLR_CYCLES);
                        cfg_reset_out_reg <= 1'b1;
                        busy_reg          <= 1'b1;
                    end
                end

                CLEAR: begin
                    // Hold the chain reset for CLR_CYCLES cycles, then ask
                    // for the first word.
                    if (clr_cnt_reg <= CC_W'(1)) begin
                        state_reg         <= LOAD;
                        clr_cnt_reg       <= '0;
                        cfg_reset_out_reg <= 1'b0;
                        word_ready_reg    <= 1'b1;
                    end else begin
                        clr_cnt_reg <= clr_cnt_reg - CC_W'(1);
                    end
                end

                LOAD: begin
                    // Wait as long as needed; on a handshake present bit 0
                    // immediately and keep the rest for the following cycles.
                    if (word_valid) begin
                        state_reg       <= SHIFT;
                        shreg_reg       <= word_next;
                        word_cnt_reg    <= take_cnt;
                        word_ready_reg  <= 1'b0;
                        cfg_bit_out_reg <= word_data[0];
                        cfg_shift_reg   <= 1'b1;
                    end
                end

                SHIFT: begin
                    // One chain bit is presented during every cycle spent here.
                    if (bits_left_reg != '0) begin
                        bits_left_reg <= bits_left_reg - BL_W'(1);
                    end
                    if (word_cnt_reg != '0) begin
                        word_cnt_reg <= word_cnt_reg - BL_W'(1);
                    end
                    if (word_cnt_reg <= BL_W'(1)) begin
                        // Last bit of this word is on the chain this cycle.
                        cfg_shift_reg   <= 1'b0;
                        cfg_bit_out_reg <= 1'b0;
                        shreg_reg       <= '0;
                        if (bits_left_reg <= BL_W'(1)) begin
                            state_reg <= FIN;
                            done_reg  <= 1'b1;
                        end else begin
                            state_reg      <= LOAD;
                            word_ready_reg <= 1'b1;
                        end
                    end else begin
                        cfg_bit_out_reg <= shreg_reg[0];
                        shreg_reg       <= shreg_next;
                    end
                end

                FIN: begin
                    // done has been high for this one cycle; release busy.
                    state_reg <= IDLE;
                    done_reg  <= 1'b0;
                    busy_reg  <= 1'b0;
                end

                default: begin
                    state_reg         <= IDLE;
                    word_ready_reg    <= 1'b0;
                    cfg_bit_out_reg   <= 1'b0;
                    cfg_shift_reg     <= 1'b0;
                    cfg_reset_out_reg <= 1'b0;
                    busy_reg          <= 1'b0;
                    done_reg          <= 1'b0;
                end
            endcase
        end
    end

    assign word_ready    = word_ready_reg;
    assign cfg_bit_out   = cfg_bit_out_reg;
    assign cfg_shift     = cfg_shift_reg;
    assign cfg_reset_out = cfg_reset_out_reg;
    assign busy          = busy_reg;
    assign done          = done_reg;

endmodule

// File: tb/tb_config_loader.sv
// Directed bench for config_loader: a 14-bit chain instance and a 16-bit
// exact-fit instance, both with 8-bit words.
module tb_config_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // 14-bit chain instance
    logic       reset, cfg_start, word_valid;
    logic [7:0] word_data;
    logic       word_ready, cfg_bit_out, cfg_shift, cfg_reset_out, busy, done;

    // 16-bit chain instance
    logic       reset16, start16, valid16;
    logic [7:0] data16;
    logic       ready16, bit16, shift16, rst_out16, busy16, done16;

    config_loader #(.WORD_W(8), .CHAIN_LEN(14), .CLR_CYCLES(2)) dut (
        .clk(clk), .reset(reset), .cfg_start(cfg_start),
        .word_valid(word_valid), .word_ready(word_ready), .word_data(word_data),
        .cfg_bit_out(cfg_bit_out), .cfg_shift(cfg_shift),
        .cfg_reset_out(cfg_reset_out), .busy(busy), .done(done)
    );

    config_loader #(.WORD_W(8), .CHAIN_LEN(16), .CLR_CYCLES(2)) dut16 (
        .clk(clk), .reset(reset16), .cfg_start(start16),
        .word_valid(valid16), .word_ready(ready16), .word_data(data16),
        .cfg_bit_out(bit16), .cfg_shift(shift16),
        .cfg_reset_out(rst_out16), .busy(busy16), .done(done16)
    );

    int total = 0;
    int bad   = 0;

    // Monitor state for the 14-bit instance
    int          cyc = 0;
    int          shift_cnt, done_cnt, hs_cnt, clr_cnt, stray_bit;
    int          last_shift_cyc, done_cyc;
    logic [31:0] stream;

    // Monitor state for the 16-bit instance
    int          shift_cnt16, done_cnt16, hs_cnt16, last_shift16, done_cyc16;
    logic [31:0] stream16;

    // Sample both instances on the falling edge, away from the active edge.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (cfg_shift) begin
            if (shift_cnt < 32) stream[shift_cnt] = cfg_bit_out;
            shift_cnt = shift_cnt + 1;
            last_shift_cyc = cyc;
        end else if (cfg_bit_out) begin
            stray_bit = stray_bit + 1;
        end
        if (done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
        if (word_ready && word_valid) hs_cnt = hs_cnt + 1;
        if (cfg_reset_out) clr_cnt = clr_cnt + 1;

        if (shift16) begin
            if (shift_cnt16 < 32) stream16[shift_cnt16] = bit16;
            shift_cnt16 = shift_cnt16 + 1;
            last_shift16 = cyc;
        end
        if (done16) begin
            done_cnt16 = done_cnt16 + 1;
            done_cyc16 = cyc;
        end
        if (ready16 && valid16) hs_cnt16 = hs_cnt16 + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) else begin
            bad = bad + 1;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        shift_cnt = 0; done_cnt = 0; hs_cnt = 0; clr_cnt = 0; stray_bit = 0;
        last_shift_cyc = 0; done_cyc = -1; stream = '0;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_outs"},
              {26'd0, word_ready, cfg_bit_out, cfg_shift, cfg_reset_out, busy, done},
              32'd0);
    endtask

    // Wait (bounded) until word_ready is visible; returns 1 on success.
    task automatic wait_ready(input string tag, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (word_ready) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) check({tag, "_ready_timeout"}, 32'd0, 32'd1);
    endtask

    // Full load with two words; optional stall in the second LOAD and an
    // optional cfg_start pulse during the first SHIFT.
    task automatic do_load(input string tag, input logic [7:0] w0, input logic [7:0] w1,
                           input int stall, input bit poke_start, input logic [31:0] exp_stream);
        bit ok;
        clear_mon();
        cfg_start = 1'b1; word_valid = 1'b1; word_data = w0;
        tick();
        cfg_start = 1'b0;
        wait_ready(tag, ok);
        tick();                     // first handshake on this edge
        word_data = w1;
        if (poke_start) begin
            cfg_start = 1'b1;
            tick();
            cfg_start = 1'b0;
        end
        wait_ready(tag, ok);
        if (stall > 0) begin
            word_valid = 1'b0;
            for (int i = 0; i < stall; i++) begin
                tick();
                check({tag, "_stall_ready"}, {31'd0, word_ready}, 32'd1);
                check({tag, "_stall_shift"}, {31'd0, cfg_shift}, 32'd0);
            end
            word_valid = 1'b1;
        end
        tick();                     // second handshake
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        check({tag, "_done_seen"}, {31'd0, ok}, 32'd1);
        check({tag, "_busy_with_done"}, {31'd0, busy}, 32'd1);
        word_valid = 1'b0;
        tick();
        check({tag, "_busy_after_done"}, {30'd0, busy, done}, 32'd0);
        tick(); tick();
        check({tag, "_shift_cnt"}, shift_cnt, 32'd14);
        check({tag, "_stream"}, stream, exp_stream);
        check({tag, "_done_cnt"}, done_cnt, 32'd1);
        check({tag, "_handshakes"}, hs_cnt, 32'd2);
        check({tag, "_clr_cycles"}, clr_cnt, 32'd2);
        check({tag, "_done_latency"}, done_cyc, last_shift_cyc + 1);
        check({tag, "_stray_bit"}, stray_bit, 32'd0);
        $display("load %s: shifts=%0d stream=%0h done=%0d hs=%0d", tag, shift_cnt, stream, done_cnt, hs_cnt);
    endtask

    initial begin
        bit ok;
        reset = 1'b1; cfg_start = 1'b0; word_valid = 1'b0; word_data = '0;
        reset16 = 1'b1; start16 = 1'b0; valid16 = 1'b0; data16 = '0;
        shift_cnt16 = 0; done_cnt16 = 0; hs_cnt16 = 0; last_shift16 = 0;
        done_cyc16 = -1; stream16 = '0;
        clear_mon();
        tick(); tick();
        check_outputs_zero("reset");
        reset = 1'b0; reset16 = 1'b0;
        tick();
        check_outputs_zero("idle");

        // Valid alone in IDLE must not start anything or be consumed.
        word_valid = 1'b1; word_data = 8'h55;
        tick(); tick();
        check("idle_valid_busy", {31'd0, busy}, 32'd0);
        check("idle_valid_hs", hs_cnt, 32'd0);
        word_valid = 1'b0;

        // Basic load: A5, 3C -> 1,0,1,0,0,1,0,1,0,0,1,1,1,1
        do_load("basic", 8'hA5, 8'h3C, 0, 1'b0, 32'h0000_3CA5);
        // Backpressure: 5-cycle stall before the second word
        do_load("stall", 8'hA5, 8'h3C, 5, 1'b0, 32'h0000_3CA5);
        // Discard of unused bits: second word FF -> only 6 ones shifted
        do_load("discard", 8'hA5, 8'hFF, 0, 1'b0, 32'h0000_3FA5);
        // cfg_start pulsed during SHIFT is ignored
        do_load("poke", 8'hA5, 8'h3C, 0, 1'b1, 32'h0000_3CA5);

        // Reset mid-operation after the 4th shifted bit
        clear_mon();
        cfg_start = 1'b1; word_valid = 1'b1; word_data = 8'hA5;
        tick();
        cfg_start = 1'b0;
        wait_ready("midrst", ok);
        tick();                     // handshake: bit 0 on the chain
        word_data = 8'h3C;
        tick(); tick(); tick();     // bit 3 (the 4th) on the chain
        reset = 1'b1;
        tick();
        check_outputs_zero("midrst");
        reset = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        check("midrst_shift_cnt", shift_cnt, 32'd4);
        check("midrst_stream", stream, 32'h0000_0005);
        check("midrst_no_done", done_cnt, 32'd0);
        check("midrst_idle", {31'd0, busy}, 32'd0);
        word_valid = 1'b0;
        do_load("after_rst", 8'hA5, 8'h3C, 0, 1'b0, 32'h0000_3CA5);

        // Reset wins over a simultaneous cfg_start
        reset = 1'b1; cfg_start = 1'b1;
        tick();
        reset = 1'b0; cfg_start = 1'b0;
        tick();
        check("rst_prio_busy", {30'd0, busy, cfg_reset_out}, 32'd0);

        // Exact fit on the 16-bit chain: 01, 80 -> 1, 14 zeros, 1
        start16 = 1'b1; valid16 = 1'b1; data16 = 8'h01;
        tick();
        start16 = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (ready16) begin ok = 1'b1; break; end
            tick();
        end
        check("fit_ready1", {31'd0, ok}, 32'd1);
        tick();
        data16 = 8'h80;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done16) begin ok = 1'b1; break; end
            tick();
        end
        check("fit_done_seen", {31'd0, ok}, 32'd1);
        valid16 = 1'b0;
        tick(); tick();
        check("fit_busy", {31'd0, busy16}, 32'd0);
        check("fit_shift_cnt", shift_cnt16, 32'd16);
        check("fit_stream", stream16, 32'h0000_8001);
        check("fit_handshakes", hs_cnt16, 32'd2);
        check("fit_done_cnt", done_cnt16, 32'd1);
        check("fit_done_latency", done_cyc16, last_shift16 + 1);
        $display("load fit: shifts=%0d stream=%0h done=%0d hs=%0d", shift_cnt16, stream16, done_cnt16, hs_cnt16);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
